// File: rtl/vita_tx_chan_arbiter.sv
// vita_tx_chan_arbiter: shares one TX DSP/DAC chain between two vita_tx_control
// channels, one burst at a time, with a programmable guard gap between grants.
// Optional feature macro: ARB_STATS_EN (per-channel 16-bit grant counters).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; pick a requester from the registered requests
// GRANT0  | channel 0 owns the chain until run0 drops
// GRANT1  | channel 1 owns the chain until run1 drops
// GUARD   | chain idle for the programmed guard gap
module vita_tx_chan_arbiter #(
  parameter int BASE  = 0,
  parameter int WIDTH = 32
) (
  input  logic             dac_clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic             run0,
  input  logic [WIDTH-1:0] sample0,
  output logic             strobe0,
  input  logic             run1,
  input  logic [WIDTH-1:0] sample1,
  output logic             strobe1,
  input  logic             strobe,
  output logic [WIDTH-1:0] sample,
  output logic             run,
  output logic [1:0]       grant,
  output logic [15:0]      burst_cnt0,
  output logic [15:0]      burst_cnt1,
  output logic [31:0]      debug
);

  localparam logic [7:0] POLICY_ADDR = 8'(BASE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_GUARD  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] gcnt_q, gcnt_d;
  logic        req0_q, req0_d, req1_q, req1_d;
  logic        fixed_pri_q, fixed_pri_d;
  logic        en0_q, en0_d, en1_q, en1_d;
  logic [15:0] guard_q, guard_d;
  logic        grant_start0, grant_start1;

  // Bits [15:3] of the policy word are reserved.
  logic unused_set_data;
  assign unused_set_data = ^set_data[15:3];

  // Policy register decode; survives clear, only reset zeroes it.
  always_comb begin
    fixed_pri_d = fixed_pri_q;
    en0_d       = en0_q;
    en1_d       = en1_q;
    guard_d     = guard_q;
    if (set_stb && (set_addr == POLICY_ADDR)) begin
      fixed_pri_d = set_data[0];
      en0_d       = set_data[1];
      en1_d       = set_data[2];
      guard_d     = set_data[31:16];
    end
  end

  // Policy register flops.
  always_ff @(posedge dac_clk) begin
    if (reset) begin
      fixed_pri_q <= 1'b0;
      en0_q       <= 1'b0;
      en1_q       <= 1'b0;
      guard_q     <= '0;
    end else begin
      fixed_pri_q <= fixed_pri_d;
      en0_q       <= en0_d;
      en1_q       <= en1_d;
      guard_q     <= guard_d;
    end
  end

  // Requests are registered once so IDLE arbitrates on stable values.
  always_comb begin
    req0_d = run0 & en0_q;
    req1_d = run1 & en1_q;
  end

  // Next-state, datapath mux and strobe routing.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gcnt_d       = gcnt_q;
    run          = 1'b0;
    grant        = 2'b00;
    sample       = '0;
    strobe0      = 1'b0;
    strobe1      = 1'b0;
    grant_start0 = 1'b0;
    grant_start1 = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Tie goes to ch0 under fixed priority, otherwise to the channel not served last.
        if (req0_q && (!req1_q || fixed_pri_q || last_q)) begin
          state_d      = ST_GRANT0;
          last_d       = 1'b0;
          grant_start0 = 1'b1;
        end else if (req1_q) begin
          state_d      = ST_GRANT1;
          last_d       = 1'b1;
          grant_start1 = 1'b1;
        end
      end
      ST_GRANT0: begin
        run     = 1'b1;
        grant   = 2'b01;
        sample  = sample0;
        strobe0 = strobe;
        if (!run0) begin
          if (guard_q == 16'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GUARD;
            gcnt_d  = guard_q - 16'd1;
          end
        end
      end
      ST_GRANT1: begin
        run     = 1'b1;
        grant   = 2'b10;
        sample  = sample1;
        strobe1 = strobe;
        if (!run1) begin
          if (guard_q == 16'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GUARD;
            gcnt_d  = guard_q - 16'd1;
          end
        end
      end
      default: begin
        if (gcnt_q == 16'd0) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q - 16'd1;
        end
      end
    endcase
  end

  // Arbiter state flops; last starts at 1 so ch0 takes the first round-robin tie.
  always_ff @(posedge dac_clk) begin
    if (reset || clear) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      gcnt_q  <= '0;
      req0_q  <= 1'b0;
      req1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gcnt_q  <= gcnt_d;
      req0_q  <= req0_d;
      req1_q  <= req1_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] burst_cnt0_q, burst_cnt0_d, burst_cnt1_q, burst_cnt1_d;

  // Count grants issued per channel; wraps naturally at 16 bits.
  always_comb begin
    burst_cnt0_d = burst_cnt0_q;
    burst_cnt1_d = burst_cnt1_q;
    if (grant_start0) burst_cnt0_d = burst_cnt0_q + 16'd1;
    if (grant_start1) burst_cnt1_d = burst_cnt1_q + 16'd1;
  end

  // Grant counter flops.
  always_ff @(posedge dac_clk) begin
    if (reset || clear) begin
      burst_cnt0_q <= '0;
      burst_cnt1_q <= '0;
    end else begin
      burst_cnt0_q <= burst_cnt0_d;
      burst_cnt1_q <= burst_cnt1_d;
    end
  end

  assign burst_cnt0 = burst_cnt0_q;
  assign burst_cnt1 = burst_cnt1_q;
`else
  logic unused_grant_start;
  assign unused_grant_start = grant_start0 | grant_start1;
  assign burst_cnt0 = '0;
  assign burst_cnt1 = '0;
`endif

  assign debug = {state_q, last_q, run0, run1, strobe, strobe0, strobe1, 24'b0};

endmodule
